// File: rtl/plab2_proc_intr_req_queue.sv
// Per-core interrupt request front-end: cause FIFO plus rq/ack/val handshake
// toward the interrupt controller and val/rdy delivery back to the core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing in flight; leave when the FIFO holds an entry
// REQ      | intr_rq high for the head entry until intr_ack is sampled
// WAIT_VAL | acked, waiting for intr_val; retry on timer expiry
// DELIVER  | dlv_val high with the head cause until the core takes it
module plab2_proc_intr_req_queue #(
    parameter int DEPTH   = 4,
    parameter int CAUSE_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    input  logic [CAUSE_W-1:0]       enq_cause,
    input  logic                     prio_set,
    input  logic                     prio_clr,
    output logic                     intr_rq,
    output logic                     intr_set,
    input  logic                     intr_ack,
    input  logic                     intr_val,
    output logic                     dlv_val,
    input  logic                     dlv_rdy,
    output logic [CAUSE_W-1:0]       dlv_cause,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_VAL = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic                 timeout_hit;

    logic [CAUSE_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 overflow_q;
    logic                 timeout_err_q;
    logic                 intr_set_q;

    logic                 enq_fire;
    logic                 pop;

    assign enq_rdy  = (count_q != CW'(DEPTH));
    assign enq_fire = enq_val & enq_rdy;
    assign pop      = (state_q == DELIVER) & dlv_rdy;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // ack takes precedence; a simultaneous intr_val is ignored here
                if (intr_ack) begin
                    state_d = WAIT_VAL;
                    timer_d = 8'd0;
                end
            end
            WAIT_VAL: begin
                if (intr_val) begin
                    state_d = DELIVER;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    state_d     = REQ;
                    timeout_hit = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DELIVER: begin
                if (dlv_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (enq_fire && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !enq_fire) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Writes only land on free slots, so the head entry is never overwritten.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr_q] <= enq_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            intr_set_q    <= 1'b0;
        end else begin
            if (enq_val && !enq_rdy) begin
                overflow_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
            if (prio_clr) begin
                intr_set_q <= 1'b0;
            end else if (prio_set) begin
                intr_set_q <= 1'b1;
            end
        end
    end

    assign intr_rq     = (state_q == REQ);
    assign dlv_val     = (state_q == DELIVER);
    assign dlv_cause   = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign intr_set    = intr_set_q;

endmodule

// File: tb/tb_plab2_proc_intr_req_queue.sv
// Bench for plab2_proc_intr_req_queue: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_plab2_proc_intr_req_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       enq_val, enq_rdy;
    logic [7:0] enq_cause;
    logic       prio_set, prio_clr;
    logic       intr_rq, intr_set, intr_ack, intr_val;
    logic       dlv_val, dlv_rdy;
    logic [7:0] dlv_cause;
    logic [2:0] count;
    logic       overflow, timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    plab2_proc_intr_req_queue #(.DEPTH(4), .CAUSE_W(8), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_val    (enq_val),
        .enq_rdy    (enq_rdy),
        .enq_cause  (enq_cause),
        .prio_set   (prio_set),
        .prio_clr   (prio_clr),
        .intr_rq    (intr_rq),
        .intr_set   (intr_set),
        .intr_ack   (intr_ack),
        .intr_val   (intr_val),
        .dlv_val    (dlv_val),
        .dlv_rdy    (dlv_rdy),
        .dlv_cause  (dlv_cause),
        .count      (count),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic       ev;
        logic [7:0] cause;
        logic       ack;
        logic       val;
        logic       rdy;
        logic       ps;
        logic       pc;
        logic       e_rq;
        logic       e_dv;
        logic [7:0] e_cause;
        logic [2:0] e_cnt;
        logic       e_iset;
    } vec_t;

    vec_t vt [19];

    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_DLV = 3;
    logic [7:0] mq [$];
    int         mph, mwc;
    logic       movf, mterr, miset;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rq();
        int k = 0;
        while (intr_rq !== 1'b1 && k < 30) begin
            cyc();
            k++;
        end
        chk("wait_rq", {31'd0, intr_rq}, 32'd1);
    endtask

    task automatic get_dlv();
        wait_rq();
        intr_ack = 1'b1;
        cyc();
        intr_ack = 1'b0;
        intr_val = 1'b1;
        cyc();
        intr_val = 1'b0;
    endtask

    task automatic service(input logic [7:0] exp);
        get_dlv();
        chk("svc_dlv_val", {31'd0, dlv_val}, 32'd1);
        chk("svc_cause", {24'd0, dlv_cause}, {24'd0, exp});
        dlv_rdy = 1'b1;
        cyc();
        dlv_rdy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          ev cause   ack  val  rdy  ps   pc   rq   dv   cause  cnt   iset
        vt[0]  = '{1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 3'd1, 1'b0};
        vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[8]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd1, 1'b0};
        vt[13] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0};
        vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 3'd1, 1'b0};
        vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

        reset = 1'b1;
        enq_val = 1'b0; enq_cause = 8'h00; prio_set = 1'b0; prio_clr = 1'b0;
        intr_ack = 1'b0; intr_val = 1'b0; dlv_rdy = 1'b0;
        cyc();
        cyc();
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
        chk("rst_rq", {31'd0, intr_rq}, 32'd0);
        chk("rst_dlv_val", {31'd0, dlv_val}, 32'd0);
        chk("rst_iset", {31'd0, intr_set}, 32'd0);
        chk("rst_flags", {30'd0, overflow, timeout_err}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            enq_val  = vt[i].ev;  enq_cause = vt[i].cause;
            intr_ack = vt[i].ack; intr_val  = vt[i].val;
            dlv_rdy  = vt[i].rdy; prio_set  = vt[i].ps; prio_clr = vt[i].pc;
            cyc();
            chk($sformatf("vec%0d_rq", i), {31'd0, intr_rq}, {31'd0, vt[i].e_rq});
            chk($sformatf("vec%0d_dlv_val", i), {31'd0, dlv_val}, {31'd0, vt[i].e_dv});
            if (vt[i].e_dv)
                chk($sformatf("vec%0d_cause", i), {24'd0, dlv_cause}, {24'd0, vt[i].e_cause});
            chk($sformatf("vec%0d_count", i), {29'd0, count}, {29'd0, vt[i].e_cnt});
            chk($sformatf("vec%0d_enq_rdy", i), {31'd0, enq_rdy}, {31'd0, (vt[i].e_cnt < 3'd4)});
            chk($sformatf("vec%0d_iset", i), {31'd0, intr_set}, {31'd0, vt[i].e_iset});
            chk($sformatf("vec%0d_flags", i), {30'd0, overflow, timeout_err}, 32'd0);
        end
        enq_val = 1'b0; intr_ack = 1'b0; intr_val = 1'b0;
        dlv_rdy = 1'b0; prio_set = 1'b0; prio_clr = 1'b0;

        // fill past capacity with no ack, then drain in order
        for (int i = 1; i <= 5; i++) begin
            enq_val = 1'b1;
            enq_cause = 8'(i);
            cyc();
            if (i == 4) begin
                chk("full_enq_rdy", {31'd0, enq_rdy}, 32'd0);
                chk("full_count", {29'd0, count}, 32'd4);
                chk("full_no_ovf", {31'd0, overflow}, 32'd0);
            end
        end
        enq_val = 1'b0;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {29'd0, count}, 32'd4);
        for (int i = 1; i <= 4; i++) service(8'(i));
        chk("drain_count", {29'd0, count}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // ack without val: retry after TIMEOUT cycles
        enq_val = 1'b1; enq_cause = 8'h01;
        cyc();
        enq_val = 1'b0;
        wait_rq();
        intr_ack = 1'b1;
        cyc();
        intr_ack = 1'b0;
        repeat (14) cyc();
        chk("to_pre_rq", {31'd0, intr_rq}, 32'd0);
        chk("to_pre_err", {31'd0, timeout_err}, 32'd0);
        cyc();
        chk("to_rq", {31'd0, intr_rq}, 32'd1);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_count", {29'd0, count}, 32'd1);
        service(8'h01);

        // back-pressure in DELIVER with enqueues behind the head
        enq_val = 1'b1; enq_cause = 8'h33;
        cyc();
        enq_val = 1'b0;
        get_dlv();
        for (int i = 0; i < 6; i++) begin
            enq_val = (i < 2);
            enq_cause = 8'h44 + 8'(i * 17);
            cyc();
            chk($sformatf("hold%0d_dv", i), {31'd0, dlv_val}, 32'd1);
            chk($sformatf("hold%0d_cause", i), {24'd0, dlv_cause}, 32'h33);
        end
        enq_val = 1'b0;
        chk("hold_count", {29'd0, count}, 32'd3);
        dlv_rdy = 1'b1;
        cyc();
        dlv_rdy = 1'b0;
        chk("hold_pop_count", {29'd0, count}, 32'd2);

        // reset while in WAIT_VAL with three entries
        enq_val = 1'b1; enq_cause = 8'h66; prio_set = 1'b1;
        cyc();
        enq_val = 1'b0; prio_set = 1'b0;
        wait_rq();
        intr_ack = 1'b1;
        cyc();
        intr_ack = 1'b0;
        chk("prerst_count", {29'd0, count}, 32'd3);
        chk("prerst_iset", {31'd0, intr_set}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_rq", {31'd0, intr_rq}, 32'd0);
        chk("midrst_dv", {31'd0, dlv_val}, 32'd0);
        chk("midrst_flags", {30'd0, overflow, timeout_err}, 32'd0);
        chk("midrst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
        chk("midrst_iset", {31'd0, intr_set}, 32'd0);
        cyc();
        chk("postrst_rq", {31'd0, intr_rq}, 32'd0);

        // randomized run against the reference model
        mq.delete();
        mph = P_IDLE; mwc = 0; movf = 1'b0; mterr = 1'b0; miset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int  sz;
            bit  do_pop;
            chk("rnd_rq", {31'd0, intr_rq}, {31'd0, (mph == P_REQ)});
            chk("rnd_dv", {31'd0, dlv_val}, {31'd0, (mph == P_DLV)});
            if (mph == P_DLV) chk("rnd_cause", {24'd0, dlv_cause}, {24'd0, mq[0]});
            chk("rnd_count", {29'd0, count}, mq.size());
            chk("rnd_enq_rdy", {31'd0, enq_rdy}, {31'd0, (mq.size() < 4)});
            chk("rnd_flags", {29'd0, overflow, timeout_err, intr_set}, {29'd0, movf, mterr, miset});

            enq_val   = ($urandom_range(0, 2) == 0);
            enq_cause = 8'($urandom);
            intr_ack  = ($urandom_range(0, 1) == 0);
            intr_val  = ($urandom_range(0, 9) < 2);
            dlv_rdy   = ($urandom_range(0, 2) != 0);
            prio_set  = ($urandom_range(0, 7) == 0);
            prio_clr  = ($urandom_range(0, 7) == 0);

            sz = mq.size();
            do_pop = (mph == P_DLV) && dlv_rdy;
            if (enq_val && sz == 4) movf = 1'b1;
            if (prio_clr) miset = 1'b0;
            else if (prio_set) miset = 1'b1;
            case (mph)
                P_IDLE: if (sz > 0) mph = P_REQ;
                P_REQ:  if (intr_ack) begin mph = P_WAIT; mwc = 0; end
                P_WAIT: begin
                    if (intr_val) mph = P_DLV;
                    else if (mwc == 14) begin mph = P_REQ; mterr = 1'b1; end
                    else mwc++;
                end
                default: if (dlv_rdy) mph = P_IDLE;
            endcase
            if (do_pop) void'(mq.pop_front());
            if (enq_val && sz < 4) mq.push_back(enq_cause);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
